// File: rtl/mca_sample_scheduler.sv
// mca_sample_scheduler
//   Sequences the hierarchical multi-clock FIR adder. Decimates control-vector
//   updates by a programmable ratio, issues one-cycle start pulses, waits out
//   the adder latency, captures the result and hands it downstream on a
//   valid/ready port. Sticky flags report overrun (start due while busy) and
//   dropped results (unconsumed result overwritten).
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   enable               run enable; low returns to IDLE (after any WAIT)
//   osr                  decimation ratio, latched in IDLE (0/1 = every update)
//   in_valid             control-vector update pulse
//   start                registered one-cycle start pulse to the adder
//   sample               adder result
//   out_valid/out_ready  downstream handshake
//   out_sample           captured result
//   busy                 adder computation in flight
//   overrun, dropped     sticky error flags
//   clear_flags          synchronous clear of the sticky flags
module mca_sample_scheduler #(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int LATENCY           = 12,
    parameter int OSR_WIDTH         = 8
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                enable,
    input  logic [OSR_WIDTH-1:0]                osr,
    input  logic                                in_valid,
    output logic                                start,
    input  logic signed [WIDTH_COEFFICIENT-1:0] sample,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [WIDTH_COEFFICIENT-1:0] out_sample,
    output logic                                busy,
    output logic                                overrun,
    output logic                                dropped,
    input  logic                                clear_flags
);

    typedef enum logic [1:0] {IDLE, COUNT, WAIT} state_e;

    localparam logic [7:0]           LAT = 8'(LATENCY);
    localparam logic [OSR_WIDTH-1:0] ONE = OSR_WIDTH'(1);

    state_e                              state_q, state_d;
    logic [OSR_WIDTH-1:0]                osr_q, osr_d;
    logic [OSR_WIDTH-1:0]                dcnt_q, dcnt_d;
    logic [7:0]                          lat_q, lat_d;
    logic                                start_q, start_d;
    logic                                ovalid_q, ovalid_d;
    logic signed [WIDTH_COEFFICIENT-1:0] osample_q, osample_d;
    logic                                overrun_q, overrun_d;
    logic                                dropped_q, dropped_d;

    logic terminal;
    logic capture;

    // Terminal update: this in_valid completes a decimation period.
    assign terminal = in_valid && ((osr_q <= ONE) || (dcnt_q == osr_q - ONE));
    // Latency counter holds 1 in the last WAIT cycle; the result is stable then.
    assign capture  = (state_q == WAIT) && (lat_q == 8'd1);

    always_comb begin
        state_d   = state_q;
        osr_d     = osr_q;
        dcnt_d    = dcnt_q;
        lat_d     = lat_q;
        start_d   = 1'b0;
        ovalid_d  = ovalid_q;
        osample_d = osample_q;
        overrun_d = overrun_q;
        dropped_d = dropped_q;

        case (state_q)
            IDLE: begin
                osr_d  = osr;
                dcnt_d = '0;
                if (enable) state_d = COUNT;
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    if (terminal) begin
                        dcnt_d  = '0;
                        start_d = 1'b1;
                        lat_d   = LAT;
                        state_d = WAIT;
                    end else begin
                        dcnt_d = dcnt_q + ONE;
                    end
                end
            end
            WAIT: begin
                lat_d = lat_q - 8'd1;
                // Updates keep counting; a decimation point here cannot start.
                if (in_valid) begin
                    if (terminal) begin
                        dcnt_d    = '0;
                        overrun_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + ONE;
                    end
                end
                // enable is honoured only once the in-flight result is captured.
                if (capture) state_d = enable ? COUNT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A capture coinciding with a handshake reloads without dropping.
        if (capture) begin
            osample_d = sample;
            ovalid_d  = 1'b1;
            if (ovalid_q && !out_ready) dropped_d = 1'b1;
        end else if (ovalid_q && out_ready) begin
            ovalid_d = 1'b0;
        end

        if (clear_flags) begin
            overrun_d = 1'b0;
            dropped_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            osr_q     <= '0;
            dcnt_q    <= '0;
            lat_q     <= '0;
            start_q   <= 1'b0;
            ovalid_q  <= 1'b0;
            osample_q <= '0;
            overrun_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            osr_q     <= osr_d;
            dcnt_q    <= dcnt_d;
            lat_q     <= lat_d;
            start_q   <= start_d;
            ovalid_q  <= ovalid_d;
            osample_q <= osample_d;
            overrun_q <= overrun_d;
            dropped_q <= dropped_d;
        end
    end

    assign start      = start_q;
    assign busy       = (state_q == WAIT);
    assign out_valid  = ovalid_q;
    assign out_sample = osample_q;
    assign overrun    = overrun_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_mca_sample_scheduler.sv
// Testbench for mca_sample_scheduler. A cycle-indexed reference model
// schedules each start/capture at absolute cycle numbers and compares every
// output each cycle against the DUT.
module tb_mca_sample_scheduler;

    localparam int W   = 32;
    localparam int LAT = 5;
    localparam int OW  = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic [OW-1:0] osr;
    logic          in_valid;
    logic          start;
    logic signed [W-1:0] sample;
    logic          out_valid;
    logic          out_ready;
    logic signed [W-1:0] out_sample;
    logic          busy;
    logic          overrun;
    logic          dropped;
    logic          clear_flags;

    mca_sample_scheduler #(.WIDTH_COEFFICIENT(W), .LATENCY(LAT), .OSR_WIDTH(OW)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .osr(osr), .in_valid(in_valid),
        .start(start), .sample(sample), .out_valid(out_valid), .out_ready(out_ready),
        .out_sample(out_sample), .busy(busy), .overrun(overrun), .dropped(dropped),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle numbers of the current start and capture.
    int  cyc;
    bit  m_active;
    int  m_osr, m_pulses, m_start, m_cap;
    bit  e_ovalid, e_ov, e_dr;
    logic signed [W-1:0] e_smp;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        chk("start",      W'(start),     W'(m_start == cyc));
        chk("busy",       W'(busy),      W'(cyc >= m_start && cyc <= m_cap));
        chk("out_valid",  W'(out_valid), W'(e_ovalid));
        chk("out_sample", out_sample,    e_smp);
        chk("overrun",    W'(overrun),   W'(e_ov));
        chk("dropped",    W'(dropped),   W'(e_dr));
    endtask

    task automatic model_reset();
        m_active = 0; m_osr = 0; m_pulses = 0; m_start = -1; m_cap = -1;
        e_ovalid = 0; e_ov = 0; e_dr = 0; e_smp = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then check at the negedge.
    task automatic step(input bit en, input int o, input bit iv, input logic signed [W-1:0] s,
                        input bit rdy, input bit clr);
        bit in_wait;
        int eff;
        bit n_ovalid, n_ov, n_dr;
        logic signed [W-1:0] n_smp;
        enable = en; osr = OW'(o); in_valid = iv; sample = s; out_ready = rdy; clear_flags = clr;

        in_wait  = (cyc >= m_start) && (cyc <= m_cap);
        eff      = (m_osr <= 1) ? 1 : m_osr;
        n_ovalid = e_ovalid; n_ov = e_ov; n_dr = e_dr; n_smp = e_smp;
        if (!m_active) begin
            m_osr = o; m_pulses = 0;
            if (en) m_active = 1;
        end else if (in_wait) begin
            if (iv) begin
                m_pulses++;
                if (m_pulses >= eff) begin m_pulses = 0; n_ov = 1; end
            end
            if (cyc == m_cap && !en) m_active = 0;
        end else if (!en) begin
            m_active = 0;
        end else if (iv) begin
            m_pulses++;
            if (m_pulses >= eff) begin
                m_pulses = 0; m_start = cyc + 1; m_cap = cyc + LAT;
            end
        end
        if (in_wait && cyc == m_cap) begin
            if (e_ovalid && !rdy) n_dr = 1;
            n_ovalid = 1; n_smp = s;
        end else if (e_ovalid && rdy) begin
            n_ovalid = 0;
        end
        if (clr) begin n_ov = 0; n_dr = 0; end

        @(posedge clk);
        @(negedge clk);
        cyc++;
        e_ovalid = n_ovalid; e_ov = n_ov; e_dr = n_dr; e_smp = n_smp;
        check_all();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        enable = 0; in_valid = 0; clear_flags = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; enable = 0; osr = '0; in_valid = 0; sample = '0;
        out_ready = 0; clear_flags = 0;
        cyc = 0;
        do_reset();

        // Basic decimation osr=4, in_valid every 8 cycles; osr change to 2 mid-run is ignored.
        for (int i = 0; i < 120; i++)
            step(1, (i < 60) ? 4 : 2, (i % 8) == 1, (i == 0) ? 32'sh7FFF_0001 : $signed($urandom), 1, 0);

        // Re-enter IDLE so osr=1 is latched, then back-to-back updates -> overrun.
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 30; i++)
            step(1, 1, 1, $signed($urandom), 1, 0);
        step(1, 1, 1, $signed($urandom), 1, 1);
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, $signed($urandom), 1, 0);

        // Backpressure across several captures, then release.
        for (int i = 0; i < 20; i++)
            step(1, 1, (i % 6) == 0, (i % 12 == 5) ? -32'sd5 : 32'sd9, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 1);

        // Handshake in the capture cycle: ready high continuously during captures.
        for (int i = 0; i < 24; i++)
            step(1, 1, (i % 6) == 0, $signed($urandom), 1, 0);

        // Enable dropped mid-WAIT: capture still completes, then IDLE.
        step(1, 1, 1, 0, 0, 0);
        step(0, 4, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 4, (i % 2) == 0, 32'sd1234 + i, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 39) != 0), $urandom_range(0, 5), $urandom_range(0, 1) == 1,
                 $signed($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);

        // Reset mid-WAIT: 4 cycles after start, then no further activity.
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, $signed($urandom), 0, 0);
        #2;
        do_reset();
        for (int i = 0; i < 20; i++)
            step(0, 1, 0, $signed($urandom), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
